// File: rtl/dma_test_pkg.sv
// Shared types and constants for the DMA test subsystem
// (sink reader/checker side).
package dma_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic CTRL_LEN_START = 1'b0;
  localparam logic CTRL_SEED      = 1'b1;

  localparam int STAT_SPURIOUS = 0;
  localparam int STAT_DONE     = 1;
  localparam int STAT_ERROR    = 2;
  localparam int STAT_BUSY     = 3;

  function automatic logic [31:0] pack_status(
    input logic busy,
    input logic err,
    input logic dn,
    input logic spur
  );
    logic [31:0] v;
    v = '0;
    v[STAT_BUSY]     = busy;
    v[STAT_ERROR]    = err;
    v[STAT_DONE]     = dn;
    v[STAT_SPURIOUS] = spur;
    return v;
  endfunction

endpackage

// File: rtl/dma_sink_reader_pending_ctr.sv
// Outstanding-read counter: bounded up/down count
// with full/empty flags and a look-ahead next value.
module pending_ctr #(
  parameter int MAX_PENDING = 4,
  parameter int W = $clog2(MAX_PENDING + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic [W-1:0] o_count_next,
  output logic         o_full,
  output logic         o_empty
);

  localparam logic [W-1:0] MAXV = W'(MAX_PENDING);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next;

  // inc and dec together leave the count unchanged
  always_comb begin
    w_next = r_count;
    if (i_clr) begin
      w_next = '0;
    end else if (i_inc && !i_dec) begin
      if (r_count != MAXV)
        w_next = r_count + W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_count != '0)
        w_next = r_count - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_count <= '0;
    else
      r_count <= w_next;
  end

  assign o_count      = r_count;
  assign o_count_next = w_next;
  assign o_full       = (r_count == MAXV);
  assign o_empty      = (r_count == '0);

endmodule

// File: rtl/dma_sink_reader.sv
// Avalon-MM pipelined read master that drains an
// incrementing-pattern slave and checks every word.
module dma_sink_reader
  import dma_test_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 16,
  parameter int MAX_PENDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              m_address,
  output logic              m_read,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  input  logic              m_waitrequest,
  input  logic              control_adr,
  input  logic              control_write,
  input  logic              control_read,
  input  logic [31:0]       control_data,
  output logic [31:0]       control_readdata,
  output logic              control_wait_request,
  output logic              done,
  output logic              error
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] MAXV = PW'(MAX_PENDING);

  state_t              r_state;
  logic [CNT_W-1:0]    r_len;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_received;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [DATA_W-1:0]   r_expected;
  logic                r_read;
  logic                r_done;
  logic                r_error;
  logic                r_spurious;

  logic                w_idle_or_done;
  logic                w_busy;
  logic                w_start;
  logic                w_seed;
  logic                w_accept;
  logic                w_ret;
  logic                w_spur;
  logic                w_mismatch;
  logic [CNT_W-1:0]    w_len_n;
  logic [CNT_W-1:0]    w_issued_n;
  logic [CNT_W-1:0]    w_received_n;
  logic [PW-1:0]       w_pend_cnt;
  logic [PW-1:0]       w_pend_next;
  logic                w_pend_full;
  logic                w_pend_empty;
  logic                w_unused;

  assign w_idle_or_done = (r_state == ST_IDLE)
                       || (r_state == ST_DONE);
  assign w_busy = (r_state == ST_ISSUE)
               || (r_state == ST_DRAIN);

  assign w_start = control_write
                && (control_adr == CTRL_LEN_START)
                && w_idle_or_done;
  assign w_seed  = control_write
                && (control_adr == CTRL_SEED)
                && w_idle_or_done;

  assign w_accept = r_read && !m_waitrequest;

  // a return only counts if a read is actually owed
  assign w_ret  = m_readdatavalid && w_busy
               && !w_pend_empty;
  assign w_spur = m_readdatavalid && !w_ret;
  assign w_mismatch = w_ret
                   && (m_readdata != r_expected);

  assign w_len_n = w_start
                 ? control_data[CNT_W-1:0] : r_len;
  assign w_issued_n = w_start ? '0
                    : r_issued + CNT_W'(w_accept);
  assign w_received_n = w_start ? '0
                      : r_received + CNT_W'(w_ret);

  pending_ctr #(
    .MAX_PENDING (MAX_PENDING),
    .W           (PW)
  ) u_pend (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_start),
    .i_inc        (w_accept),
    .i_dec        (w_ret),
    .o_count      (w_pend_cnt),
    .o_count_next (w_pend_next),
    .o_full       (w_pend_full),
    .o_empty      (w_pend_empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_issued   <= '0;
      r_received <= '0;
      r_err_cnt  <= '0;
      r_expected <= '0;
      r_read     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_spurious <= 1'b0;
    end else begin
      r_len      <= w_len_n;
      r_issued   <= w_issued_n;
      r_received <= w_received_n;

      if (w_seed)
        r_expected <= control_data[DATA_W-1:0];
      else if (w_ret)
        r_expected <= r_expected + DATA_W'(1);

      if (w_start)
        r_err_cnt <= '0;
      else if (w_mismatch && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + CNT_W'(1);

      r_error <= (r_error && !w_start)
              || w_mismatch || w_spur;
      r_spurious <= (r_spurious && !w_start)
                 || w_spur;

      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            if (w_len_n == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_read  <= 1'b0;
            end else begin
              r_state <= ST_ISSUE;
              r_done  <= 1'b0;
              r_read  <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (w_issued_n == r_len) begin
            r_read <= 1'b0;
            if (w_received_n == r_len) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_DRAIN;
            end
          end else begin
            r_read <= (w_pend_next < MAXV);
          end
        end
        ST_DRAIN: begin
          if (w_received_n == r_len) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_read  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    control_readdata = '0;
    if (control_read) begin
      if (control_adr == CTRL_SEED)
        control_readdata = 32'(r_err_cnt);
      else
        control_readdata = pack_status(
          w_busy, r_error, r_done, r_spurious);
    end
  end

  assign m_address            = 1'b0;
  assign m_read               = r_read;
  assign control_wait_request = 1'b0;
  assign done                 = r_done;
  assign error                = r_error;

  assign w_unused = ^{control_data, w_pend_cnt,
                      w_pend_full};

endmodule

// File: tb/tb_dma_sink_reader.sv
// Bench for dma_sink_reader: slave model plus a
// run-level reference model checked every cycle.
module tb_dma_sink_reader;

  localparam int MP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_address;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_waitrequest;
  logic        control_adr;
  logic        control_write;
  logic        control_read;
  logic [31:0] control_data;
  logic [31:0] control_readdata;
  logic        control_wait_request;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  dma_sink_reader #(
    .DATA_W      (32),
    .CNT_W       (16),
    .MAX_PENDING (MP)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .m_address            (m_address),
    .m_read               (m_read),
    .m_readdata           (m_readdata),
    .m_readdatavalid      (m_readdatavalid),
    .m_waitrequest        (m_waitrequest),
    .control_adr          (control_adr),
    .control_write        (control_write),
    .control_read         (control_read),
    .control_data         (control_data),
    .control_readdata     (control_readdata),
    .control_wait_request (control_wait_request),
    .done                 (done),
    .error                (error)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model: a run is just counts and flags
  typedef enum {M_IDLE, M_RUN, M_DONE} mphase_t;
  mphase_t     ph    = M_IDLE;
  int unsigned mlen  = 0;
  int unsigned miss  = 0;
  int unsigned mrecv = 0;
  int unsigned mpend = 0;
  int unsigned merrc = 0;
  logic [31:0] mexp  = '0;
  bit          merr  = 0;
  bit          mspur = 0;

  // slave behaviour knobs (written by the stimulus)
  logic [31:0] q[$];
  bit          hold         = 0;
  bit          rand_wait    = 0;
  bit          rand_lat     = 0;
  bit          rand_corrupt = 0;
  int          stall_at     = -1;
  int          stall_len    = 0;
  int          stall_req    = 0;
  logic [31:0] slv_base     = '0;
  int          corrupt_idx  = -1;
  logic [31:0] corrupt_val  = '0;
  int          spur_req     = 0;

  // observed by the bus process
  int          spur_ack   = 0;
  int          stall_ack  = 0;
  int          stall_left = 0;
  int          run_acc    = 0;
  int          max_pend   = 0;
  int          stall_seen = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
  endtask

  function automatic logic exp_read();
    return (ph == M_RUN) && (miss < mlen)
        && (mpend < MP);
  endfunction

  // bus process: sample at the edge, then drive slave
  initial begin
    logic [31:0] w;
    bit acc, valid, idle_done;
    m_readdatavalid = 1'b0;
    m_readdata      = '0;
    m_waitrequest   = 1'b0;
    forever begin
      @(posedge clk);
      acc = m_read && !m_waitrequest;
      if (acc) begin
        w = slv_base + 32'(run_acc);
        if (run_acc == corrupt_idx) w = corrupt_val;
        if (rand_corrupt && $urandom_range(0, 7) == 0)
          w = w ^ 32'h1;
        q.push_back(w);
        run_acc++;
      end
      if (m_read && m_waitrequest) stall_seen++;
      if (reset) begin
        ph = M_IDLE; mlen = 0; miss = 0; mrecv = 0;
        mpend = 0; merrc = 0; mexp = '0;
        merr = 0; mspur = 0;
      end else begin
        idle_done = (ph != M_RUN);
        valid = m_readdatavalid && (ph == M_RUN)
             && (mpend > 0);
        if (ph == M_RUN) begin
          if (acc) begin miss++; mpend++; end
          if (valid) begin
            mpend--;
            mrecv++;
            if (m_readdata != mexp) begin
              if (merrc < 65535) merrc++;
              merr = 1;
            end
            mexp = mexp + 32'd1;
          end
          if (mpend > max_pend) max_pend = mpend;
          if (miss == mlen && mrecv == mlen)
            ph = M_DONE;
        end
        if (control_write && idle_done) begin
          if (control_adr == 1'b0) begin
            mlen = int'(control_data[15:0]);
            miss = 0; mrecv = 0; mpend = 0;
            merrc = 0; merr = 0; mspur = 0;
            run_acc = 0; max_pend = 0;
            stall_seen = 0;
            ph = (mlen == 0) ? M_DONE : M_RUN;
          end else begin
            mexp = control_data;
          end
        end
        if (m_readdatavalid && !valid) begin
          mspur = 1;
          merr  = 1;
        end
      end
      #1;
      if (stall_req != stall_ack) begin
        stall_ack  = stall_req;
        stall_left = stall_len;
      end
      if (spur_req != spur_ack) begin
        spur_ack++;
        m_readdatavalid = 1'b1;
        m_readdata      = 32'hDEAD_BEEF;
      end else if (!hold && q.size() > 0 &&
                   (!rand_lat ||
                    $urandom_range(0, 2) != 0)) begin
        m_readdatavalid = 1'b1;
        m_readdata      = q.pop_front();
      end else begin
        m_readdatavalid = 1'b0;
      end
      if (stall_left > 0 && run_acc == stall_at) begin
        m_waitrequest = 1'b1;
        stall_left--;
      end else begin
        m_waitrequest = rand_wait
                     && ($urandom_range(0, 2) == 0);
      end
    end
  end

  // single compare process against the model
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_read", {31'b0, m_read},
          {31'b0, exp_read()});
      chk("done", {31'b0, done},
          {31'b0, ph == M_DONE});
      chk("error", {31'b0, error}, {31'b0, merr});
      chk("m_address", {31'b0, m_address}, 32'd0);
      chk("ctrl_wait", {31'b0, control_wait_request},
          32'd0);
      if (control_read) begin
        if (control_adr)
          chk("ctrl_errcnt", control_readdata, merrc);
        else
          chk("ctrl_status", control_readdata,
              {28'b0, ph == M_RUN, merr,
               ph == M_DONE, mspur});
      end
    end
  end

  task automatic ctrl_wr(logic adr, logic [31:0] d);
    @(posedge clk); #2;
    control_adr   = adr;
    control_data  = d;
    control_write = 1'b1;
    @(posedge clk); #2;
    control_write = 1'b0;
  endtask

  task automatic ctrl_rd(logic adr,
                         output logic [31:0] d);
    @(posedge clk); #2;
    control_adr  = adr;
    control_read = 1'b1;
    #1 d = control_readdata;
    @(negedge clk); #1;
    control_read = 1'b0;
  endtask

  task automatic run(logic [31:0] seed, int len);
    ctrl_wr(1'b1, seed);
    ctrl_wr(1'b0, 32'(len));
  endtask

  task automatic wait_done();
    for (int c = 0; c < 3000 && !done; c++)
      @(negedge clk);
    chk("done_timeout", {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    reset         = 1'b0;
    control_adr   = 1'b0;
    control_write = 1'b0;
    control_read  = 1'b0;
    control_data  = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_m_read", {31'b0, m_read}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_rdata", control_readdata, 32'd0);
    chk("rst_wait", {31'b0, control_wait_request}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // clean run of 8 words, 1-cycle return latency
    slv_base = 32'd0;
    run(32'd0, 8);
    wait_done();
    chk("t1_acc", run_acc, 32'd8);
    chk("t1_maxpend", {31'b0, max_pend <= MP}, 32'd1);
    ctrl_rd(1'b0, rd); chk("t1_status", rd, 32'h2);
    ctrl_rd(1'b1, rd); chk("t1_errcnt", rd, 32'd0);

    // one corrupted word: 5,6,99,8
    slv_base    = 32'd5;
    corrupt_idx = 2;
    corrupt_val = 32'd99;
    run(32'd5, 4);
    wait_done();
    corrupt_idx = -1;
    ctrl_rd(1'b1, rd); chk("t2_errcnt", rd, 32'd1);
    ctrl_rd(1'b0, rd); chk("t2_status", rd, 32'h6);

    // 3-cycle stall on the second read
    slv_base  = 32'd100;
    stall_at  = 1;
    stall_len = 3;
    stall_req++;
    run(32'd100, 6);
    wait_done();
    stall_at = -1;
    chk("t3_acc", run_acc, 32'd6);
    chk("t3_stall", stall_seen, 32'd3);
    ctrl_rd(1'b0, rd); chk("t3_status", rd, 32'h2);

    // returns withheld: issue stops at MAX_PENDING
    hold     = 1;
    slv_base = 32'd0;
    run(32'd0, 8);
    repeat (12) @(negedge clk);
    chk("t4_acc_held", run_acc, 32'd4);
    chk("t4_read_held", {31'b0, m_read}, 32'd0);
    hold = 0;
    wait_done();
    chk("t4_acc", run_acc, 32'd8);
    ctrl_rd(1'b0, rd); chk("t4_status", rd, 32'h2);

    // expected value wraps through zero
    slv_base = 32'hFFFF_FFFE;
    run(32'hFFFF_FFFE, 4);
    wait_done();
    ctrl_rd(1'b1, rd); chk("t4_wrap_errcnt", rd, 0);
    ctrl_rd(1'b0, rd); chk("t4_wrap_status", rd, 2);

    // zero-length run finishes at once
    run(32'd0, 0);
    chk("t5_len0_done", {31'b0, done}, 32'd1);
    repeat (3) @(negedge clk);
    chk("t5_len0_acc", run_acc, 32'd0);

    // start write while busy is ignored
    hold     = 1;
    slv_base = 32'd0;
    run(32'd0, 6);
    ctrl_wr(1'b0, 32'd2);
    repeat (3) @(negedge clk);
    hold = 0;
    wait_done();
    chk("t5_ignored_acc", run_acc, 32'd6);

    // stray readdatavalid after completion
    spur_req++;
    repeat (3) @(negedge clk);
    ctrl_rd(1'b0, rd); chk("t5_spur_status", rd, 32'h7);
    ctrl_rd(1'b1, rd); chk("t5_spur_errcnt", rd, 0);

    // reset with two reads outstanding
    hold     = 1;
    slv_base = 32'd0;
    run(32'd0, 6);
    for (int c = 0; c < 200 && run_acc < 2; c++)
      @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_read", {31'b0, m_read}, 32'd0);
    chk("t6_rst_done", {31'b0, done}, 32'd0);
    chk("t6_rst_error", {31'b0, error}, 32'd0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    hold = 0;
    repeat (6) @(negedge clk);
    ctrl_rd(1'b0, rd); chk("t6_spur_status", rd, 32'h5);
    q.delete();
    slv_base = 32'd0;
    run(32'd0, 2);
    wait_done();
    chk("t6_acc", run_acc, 32'd2);
    ctrl_rd(1'b0, rd); chk("t6_status", rd, 32'h2);

    // randomized runs: stalls, latency, corruption
    rand_wait    = 1;
    rand_lat     = 1;
    rand_corrupt = 1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] s;
      int          n;
      s = $urandom;
      n = $urandom_range(1, 24);
      slv_base = s;
      run(s, n);
      wait_done();
      chk("rnd_acc", run_acc, 32'(n));
      ctrl_rd(1'b1, rd);
      ctrl_rd(1'b0, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dma_sink_reader.md
Name: dma_sink_reader

Overview:
- Avalon-MM pipelined read master that drains the incrementing-pattern data slave (data_slave: address / read / readdata / readdatavalid / waitrequest).
- Reads a programmed number of words and checks each word against an expected incrementing sequence.
- Reports busy, done, error and error count through a small control slave.
- Sits beside the data source in the test subsystem as its consumer and checker.

Parameters:
- DATA_W, 32, width of master readdata and of the expected-value register.
- CNT_W, 16, width of the length, issued, received and error counters.
- MAX_PENDING, 4, maximum outstanding reads (issued but no readdatavalid yet); must be at least 1.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- m_address  out  1  master address; constant 0.
- m_read  out  1  read request.
- m_readdata  in  DATA_W  returned read data.
- m_readdatavalid  in  1  m_readdata qualifier.
- m_waitrequest  in  1  slave stall; a request is accepted when m_read=1 and m_waitrequest=0.
- control_adr  in  1  control register select.
- control_write  in  1  control write strobe.
- control_read  in  1  control read strobe.
- control_data  in  32  control writedata.
- control_readdata  out  32  control readdata; combinational, read latency 0.
- control_wait_request  out  1  always 0.
- done  out  1  run complete; sticky until the next start.
- error  out  1  at least one mismatch or spurious return in the current run.

Behaviour:
- Reset: m_read=0, m_address=0, done=0, error=0, control_readdata=0, control_wait_request=0. State=IDLE, all counters 0, expected=0.
- Control writes:
  - adr1: expected <= control_data[DATA_W-1:0]. Accepted only in IDLE or DONE.
  - adr0: len <= control_data[CNT_W-1:0], then start. Accepted only in IDLE or DONE; ignored while busy.
- Control reads (combinational):
  - adr0 = {28'b0, busy, error, done, spurious}.
  - adr1 = zero-extended err_cnt.
- FSM states:
  - IDLE: start with len=0 -> DONE next cycle, no reads issued; start with len>0 -> ISSUE. On start: issued, received, err_cnt, pending cleared; done=0, error=0.
  - ISSUE: m_read=1 while issued<len and pending<MAX_PENDING, otherwise 0. On acceptance, issued++ and pending++. When the final read is accepted, m_read drops the next cycle -> DRAIN (or straight to DONE if received==len on the same edge).
  - DRAIN: m_read=0; wait until received==len -> DONE.
  - DONE: done=1; a start write restarts the run exactly as from IDLE.
- m_read is registered. It never depends combinationally on m_waitrequest and stays high across stall cycles.
- Return handling: each m_readdatavalid in ISSUE/DRAIN does pending--, received++, expected <= expected+1 (wraps mod 2^DATA_W). If m_readdata != expected: err_cnt++ (saturates at 2^CNT_W-1) and error=1.
- Simultaneous acceptance and readdatavalid in one cycle: pending unchanged.
- Spurious return (m_readdatavalid in IDLE/DONE, or while pending==0): ignored for counting; sets sticky spurious=1 and error=1.
- Latency: first m_read is asserted 1 cycle after the start write; done rises 1 cycle after the last readdatavalid.
- Reset mid-run: everything cleared asynchronously. Outstanding returns that arrive after reset deasserts are treated as spurious.

Decomposition:
- Package dma_test_pkg:
  - state enum (IDLE, ISSUE, DRAIN, DONE);
  - control address constants CTRL_LEN_START=0, CTRL_SEED=1;
  - status bit indices.
- Sub-module pending_ctr: up/down counter bounded by MAX_PENDING with a full flag, instantiated once.

Test Plan:
- Seed=0, len=8, m_waitrequest=0, slave returns 0..7 one cycle after each read: 8 accepted reads, done=1, error=0, err_cnt=0, never more than 4 outstanding.
- Seed=5, len=4, slave returns 5,6,99,8: err_cnt=1, error=1, done=1; the 4th word is still judged correct (expected keeps incrementing).
- m_waitrequest held high for 3 cycles on the 2nd read: m_read stays high throughout, exactly len acceptances, no duplicate or dropped reads.
- Slave withholds readdatavalid: m_read stops after 4 accepted reads, then resumes one cycle after the first return. Also check seed=32'hFFFFFFFE, len=4 wraps through 0 with no error.
- len=0 start -> done=1 next cycle with no m_read. A start write during ISSUE is ignored. A readdatavalid in IDLE sets the spurious and error bits.
- Assert reset with 2 reads pending: outputs clear immediately. Later returns set spurious. A new start of len=2 completes normally.
